// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared definitions for the LBIST mid-section sequencer.
//   - lbist_state_e : sequencer state encoding
//   - default widths, pattern count, LFSR taps and seed
// Ports: none (package).
// -----------------------------------------------------------------------------
package lbist_pkg;

  localparam int unsigned LBIST_IN_BITS   = 41;
  localparam int unsigned LBIST_OUT_BITS  = 32;
  localparam int unsigned LBIST_PAT_COUNT = 256;
  localparam int unsigned LBIST_CNT_W     = 16;

  // Galois taps for x^41 + x^3 + 1 (bit 0 is the implicit feedback term)
  localparam logic [40:0] LBIST_LFSR_POLY = 41'h0_0000_0009;
  localparam logic [40:0] LBIST_LFSR_SEED = 41'h0_0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FRST  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_APPLY = 3'd3,
    ST_EVAL  = 3'd4,
    ST_INC   = 3'd5,
    ST_DONE  = 3'd6
  } lbist_state_e;

endpackage

// File: rtl/lbist_lfsr.sv
// -----------------------------------------------------------------------------
// lbist_lfsr
// Left-shifting Galois LFSR used as the LBIST pattern generator.
// o_next is the value the register takes at the coming clock edge, so the
// caller can capture the same value into its own output register and keep
// that register aligned with the LFSR state.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset (loads the seed)
//   i_load  in   reload the (zero-guarded) seed at the next edge
//   i_step  in   advance one Galois step at the next edge
//   o_next  out  WIDTH  next LFSR value
// -----------------------------------------------------------------------------
module lbist_lfsr
  import lbist_pkg::*;
#(
  parameter int unsigned       WIDTH = LBIST_IN_BITS,
  parameter logic [WIDTH-1:0]  POLY  = LBIST_LFSR_POLY,
  parameter logic [WIDTH-1:0]  SEED  = LBIST_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_next
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1
  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_galois;
  logic [WIDTH-1:0] w_next;

  // Next-state selection: reload has priority over stepping
  always_comb begin
    w_galois = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? POLY : {WIDTH{1'b0}});
    if (i_load) begin
      w_next = SEED_EFF;
    end else if (i_step) begin
      w_next = w_galois;
    end else begin
      w_next = r_state;
    end
  end

  // LFSR state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_EFF;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_next = w_next;

endmodule

// File: rtl/lbist_ctrl.sv
// -----------------------------------------------------------------------------
// lbist_ctrl
// Sequencer for the LBIST mid section (fault-injection logic plus faulty and
// fault-free CUT copies). For every fault in the FIL list it reseeds the
// pattern LFSR, applies PAT_COUNT patterns, compares the two CUT outputs and
// updates saturating injected/detected fault counters.
//
// Optional feature (macro LBIST_EARLY_ABORT_EN): when defined, the first
// mismatch of a fault ends its pattern run immediately. Counter results are
// unchanged; only the campaign length shrinks.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-high reset
//   start            in   campaign request, honoured in IDLE and DONE only
//   TEST_IP          out  IN_BITS   pattern to both CUTs (registered)
//   FIL_RST          out  FIL reset, one cycle at campaign start
//   FIL_INC          out  FIL advance to next fault, one-cycle pulse
//   FIL_END          in   current fault is the last one in the list
//   CUT_OP           in   OUT_BITS  faulty CUT output
//   FF_OP            in   OUT_BITS  fault-free CUT output
//   busy             out  campaign in progress
//   done             out  campaign finished, held until next start
//   faults_total     out  CNT_W  faults evaluated
//   faults_detected  out  CNT_W  faults with at least one mismatch
// -----------------------------------------------------------------------------
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned         IN_BITS   = LBIST_IN_BITS,
  parameter int unsigned         OUT_BITS  = LBIST_OUT_BITS,
  parameter int unsigned         PAT_COUNT = LBIST_PAT_COUNT,
  parameter int unsigned         CNT_W     = LBIST_CNT_W,
  parameter logic [IN_BITS-1:0]  LFSR_POLY = LBIST_LFSR_POLY,
  parameter logic [IN_BITS-1:0]  LFSR_SEED = LBIST_LFSR_SEED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IN_BITS-1:0]  TEST_IP,
  output logic                FIL_RST,
  output logic                FIL_INC,
  input  logic                FIL_END,
  input  logic [OUT_BITS-1:0] CUT_OP,
  input  logic [OUT_BITS-1:0] FF_OP,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    faults_total,
  output logic [CNT_W-1:0]    faults_detected
);

  localparam int unsigned      PC_W     = (PAT_COUNT > 1) ? $clog2(PAT_COUNT) : 1;
  localparam logic [PC_W-1:0]  PAT_LAST = PC_W'(PAT_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  lbist_state_e         r_state;
  lbist_state_e         w_state_nxt;
  logic [PC_W-1:0]      r_pat_cnt;
  logic                 r_det_flag;
  logic [IN_BITS-1:0]   r_test_ip;
  logic                 r_fil_rst;
  logic                 r_fil_inc;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_W-1:0]     r_faults_total;
  logic [CNT_W-1:0]     r_faults_detected;
  logic                 w_mismatch;
  logic                 w_last_pat;
  logic                 w_start_ok;
  logic                 w_lfsr_load;
  logic                 w_lfsr_step;
  logic [IN_BITS-1:0]   w_lfsr_next;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  assign w_mismatch  = (CUT_OP != FF_OP);
  assign w_last_pat  = (r_pat_cnt == PAT_LAST);
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_lfsr_load = (r_state == ST_LOAD);
  assign w_lfsr_step = (r_state == ST_APPLY);

  lbist_lfsr #(
    .WIDTH (IN_BITS),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_lfsr_load),
    .i_step (w_lfsr_step),
    .o_next (w_lfsr_next)
  );

  // Sequencer next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FRST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FRST: w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_APPLY;
      ST_APPLY: begin
`ifdef LBIST_EARLY_ABORT_EN
        if (w_mismatch || w_last_pat) begin
`else
        if (w_last_pat) begin
`endif
          w_state_nxt = ST_EVAL;
        end else begin
          w_state_nxt = ST_APPLY;
        end
      end
      ST_EVAL: begin
        if (FIL_END) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_INC;
        end
      end
      ST_INC: w_state_nxt = ST_LOAD;
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_FRST;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and status/strobe outputs decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_fil_rst <= 1'b0;
      r_fil_inc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fil_rst <= (w_state_nxt == ST_FRST);
      r_fil_inc <= (w_state_nxt == ST_INC);
      r_busy    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  // Per-fault pattern counter, detection flag and registered test pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat_cnt  <= {PC_W{1'b0}};
      r_det_flag <= 1'b0;
      r_test_ip  <= {IN_BITS{1'b0}};
    end else begin
      if (r_state == ST_LOAD) begin
        r_pat_cnt  <= {PC_W{1'b0}};
        r_det_flag <= 1'b0;
      end else if (r_state == ST_APPLY) begin
        r_pat_cnt  <= r_pat_cnt + PC_W'(1);
        r_det_flag <= r_det_flag | w_mismatch;
      end else begin
        r_pat_cnt  <= r_pat_cnt;
        r_det_flag <= r_det_flag;
      end
      // Capture the LFSR's next value so TEST_IP equals the LFSR state for the
      // whole APPLY phase; the last pattern is held once APPLY is left.
      if ((r_state == ST_LOAD) || ((r_state == ST_APPLY) && (w_state_nxt == ST_APPLY))) begin
        r_test_ip <= w_lfsr_next;
      end else begin
        r_test_ip <= r_test_ip;
      end
    end
  end

  // Campaign result counters: cleared on an accepted start, bumped in EVAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_faults_total    <= {CNT_W{1'b0}};
      r_faults_detected <= {CNT_W{1'b0}};
    end else if (w_start_ok) begin
      r_faults_total    <= {CNT_W{1'b0}};
      r_faults_detected <= {CNT_W{1'b0}};
    end else if (r_state == ST_EVAL) begin
      r_faults_total    <= sat_inc(r_faults_total, 1'b1);
      r_faults_detected <= sat_inc(r_faults_detected, r_det_flag);
    end else begin
      r_faults_total    <= r_faults_total;
      r_faults_detected <= r_faults_detected;
    end
  end

  assign TEST_IP         = r_test_ip;
  assign FIL_RST         = r_fil_rst;
  assign FIL_INC         = r_fil_inc;
  assign busy            = r_busy;
  assign done            = r_done;
  assign faults_total    = r_faults_total;
  assign faults_detected = r_faults_detected;

endmodule

// File: tb/tb_lbist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lbist_ctrl
// Self-checking bench for lbist_ctrl with PAT_COUNT=4, CNT_W=3 (so counter
// saturation is reachable) and a zero LFSR seed (exercising the zero guard).
// A behavioural FIL/CUT stub injects mismatches from a per-fault bitmask
// (bit j = mismatch on pattern j). Expected counts and cycle counts come from
// the masks with plain arithmetic. Honours LBIST_EARLY_ABORT_EN.
// -----------------------------------------------------------------------------
module tb_lbist_ctrl;

  localparam int PAT  = 4;
  localparam int SAT  = 7;
  localparam int MAXF = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [40:0] TEST_IP;
  logic        FIL_RST;
  logic        FIL_INC;
  logic        FIL_END;
  logic [31:0] CUT_OP;
  logic [31:0] FF_OP;
  logic        busy;
  logic        done;
  logic [2:0]  faults_total;
  logic [2:0]  faults_detected;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_rst_hi = 0;
  int          n_inc_hi = 0;
  int          n_faults = 1;
  logic [3:0]  fidx = 4'd0;
  logic [3:0]  masks [0:MAXF-1];
  logic [40:0] pat [0:PAT-1];
  logic        mm;

  lbist_ctrl #(
    .IN_BITS   (41),
    .OUT_BITS  (32),
    .PAT_COUNT (PAT),
    .CNT_W     (3),
    .LFSR_POLY (41'h0_0000_0009),
    .LFSR_SEED (41'h0_0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .TEST_IP         (TEST_IP),
    .FIL_RST         (FIL_RST),
    .FIL_INC         (FIL_INC),
    .FIL_END         (FIL_END),
    .CUT_OP          (CUT_OP),
    .FF_OP           (FF_OP),
    .busy            (busy),
    .done            (done),
    .faults_total    (faults_total),
    .faults_detected (faults_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIL stub: fault index follows FIL_RST/FIL_INC; pulse high-cycles counted
  always @(negedge clk) begin
    if (FIL_RST) begin
      fidx     <= 4'd0;
      n_rst_hi <= n_rst_hi + 1;
    end else if (FIL_INC) begin
      fidx     <= fidx + 4'd1;
      n_inc_hi <= n_inc_hi + 1;
    end
  end

  assign FIL_END = (int'(fidx) == n_faults - 1);

  // CUT stub: outputs differ when the current fault's mask flags this pattern
  always_comb begin
    mm = 1'b0;
    for (int j = 0; j < PAT; j++) begin
      if ((TEST_IP == pat[j]) && masks[fidx][j]) mm = 1'b1;
    end
    FF_OP  = TEST_IP[31:0] ^ 32'h5A5A_C3C3;
    CUT_OP = FF_OP ^ (mm ? 32'h0001_0000 : 32'h0000_0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Number of APPLY cycles a fault with mismatch mask m occupies
  function automatic int apply_len(input logic [3:0] m);
    int a;
    a = PAT;
`ifdef LBIST_EARLY_ABORT_EN
    for (int j = PAT - 1; j >= 0; j--) begin
      if (m[j]) a = j + 1;
    end
`endif
    return a;
  endfunction

  function automatic int min_sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_tip"}, 64'(TEST_IP), 64'd0);
    chk({tag, "_frst"}, 64'(FIL_RST), 64'd0);
    chk({tag, "_finc"}, 64'(FIL_INC), 64'd0);
    chk({tag, "_tot"}, 64'(faults_total), 64'd0);
    chk({tag, "_det"}, 64'(faults_detected), 64'd0);
  endtask

  // Run one campaign of nf faults using masks[]; optionally pulse start mid-run
  task automatic run_campaign(input string tag, input int nf, input bit mid_start);
    int exp_cyc, exp_det, a0, k, rst0, inc0, idx;
    n_faults = nf;
    exp_cyc  = nf;
    exp_det  = 0;
    for (int i = 0; i < nf; i++) begin
      exp_cyc += apply_len(masks[i]) + 2;
      if (masks[i] != 4'd0) exp_det++;
    end
    a0   = apply_len(masks[0]);
    rst0 = n_rst_hi;
    inc0 = n_inc_hi;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_set"}, 64'(busy), 64'd1);
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
    chk({tag, "_tot_clr"}, 64'(faults_total), 64'd0);
    chk({tag, "_det_clr"}, 64'(faults_detected), 64'd0);
    k = 0;
    while ((done !== 1'b1) && (k < 400)) begin
      tick();
      k++;
      start = mid_start && (k == 5);
      if ((k >= 2) && (k <= 2 + a0)) begin
        idx = (k - 2 < a0 - 1) ? (k - 2) : (a0 - 1);
        chk($sformatf("%s_tip%0d", tag, k), 64'(TEST_IP), 64'(pat[idx]));
      end
    end
    start = 1'b0;
    chk({tag, "_cycles"}, 64'(k), 64'(exp_cyc));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    chk({tag, "_total"}, 64'(faults_total), 64'(min_sat(nf)));
    chk({tag, "_detected"}, 64'(faults_detected), 64'(min_sat(exp_det)));
    chk({tag, "_fil_rst_n"}, 64'(n_rst_hi - rst0), 64'd1);
    chk({tag, "_fil_inc_n"}, 64'(n_inc_hi - inc0), 64'(nf - 1));
    tick();
    chk({tag, "_frozen"}, 64'(faults_total), 64'(min_sat(nf)));
  endtask

  initial begin
    logic [63:0] p;
    // Expected pattern list: zero seed replaced by 1, then Galois steps
    p = 64'd1;
    for (int j = 0; j < PAT; j++) begin
      pat[j] = p[40:0];
      p = ((p << 1) & ((64'd1 << 41) - 64'd1)) ^ (((p >> 40) & 64'd1) != 64'd0 ? 64'h9 : 64'h0);
    end
    for (int i = 0; i < MAXF; i++) masks[i] = 4'd0;
    rst   = 1'b1;
    start = 1'b0;
    #12;
    chk_quiet("reset");
    tick();
    rst = 1'b0;

    // Idle for 10 cycles with no activity
    begin
      int inc0;
      inc0 = n_inc_hi;
      for (int i = 0; i < 10; i++) tick();
      chk_quiet("idle");
      chk("idle_no_inc", 64'(n_inc_hi - inc0), 64'd0);
    end

    // Matching CUTs, 3 faults (started from IDLE)
    run_campaign("nomis", 3, 1'b0);
    // Mismatch on fault #2 at the last pattern (restart from DONE)
    masks[1] = 4'b1000;
    run_campaign("mis_last", 3, 1'b0);
    // Mismatch on fault #2 at the first pattern
    masks[1] = 4'b0001;
    run_campaign("mis_first", 3, 1'b0);

    // Reset during APPLY of fault #2: asynchronous return to reset values
    for (int i = 0; i < MAXF; i++) masks[i] = 4'd0;
    n_faults = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_abort_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("abort");
    tick();
    rst = 1'b0;
    tick();
    chk_quiet("abort_idle");
    masks[0] = 4'b0110;
    masks[2] = 4'b0100;
    run_campaign("post_abort", 3, 1'b0);

    // start pulsed while busy must be ignored
    masks[0] = 4'b0000;
    masks[1] = 4'b0010;
    masks[2] = 4'b0000;
    run_campaign("busy_start", 3, 1'b1);

    // Single fault list
    for (int i = 0; i < MAXF; i++) masks[i] = 4'd0;
    run_campaign("single", 1, 1'b0);

    // Counter saturation: 9 faults all detected on a 3-bit counter
    for (int i = 0; i < 9; i++) masks[i] = 4'b0100;
    run_campaign("sat", 9, 1'b0);

    // Randomised campaigns
    for (int r = 0; r < 5; r++) begin
      int nf;
      nf = int'($urandom_range(1, 8));
      for (int i = 0; i < MAXF; i++) begin
        masks[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      run_campaign($sformatf("rand%0d", r), nf, 1'($urandom_range(0, 1)));
    end

    // start and rst together: rst wins
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk_quiet("rst_start");
    tick();
    chk("rst_start_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
